// File: rtl/sipo_pkg.sv
// Shared constants and helpers for the sipo_register serial-in/parallel-out shifter.
package sipo_pkg;

  localparam int unsigned SIPO_DEFAULT_WIDTH = 4;

  localparam bit SIPO_DIR_LEFT  = 1'b1;
  localparam bit SIPO_DIR_RIGHT = 1'b0;

  // Bits needed to hold a bit count from 0 up to and including width.
  function automatic int unsigned sipo_cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_register.sv
// Serial-in / parallel-out shift register with synchronous active-high reset.
// Optional SIPO_WORD_VALID_EN adds a one-cycle word_valid pulse per WIDTH shifted bits.
module sipo_register
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH      = SIPO_DEFAULT_WIDTH,
  parameter bit          SHIFT_LEFT = SIPO_DIR_LEFT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             shift,
`ifdef SIPO_WORD_VALID_EN
  output logic             word_valid,
`endif
  output logic [WIDTH-1:0] parallel_out
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Next shift-register contents; direction fixed at elaboration.
  always_comb begin
    data_d = data_q;
    if (shift) begin
      if (SHIFT_LEFT) begin
        data_d = {data_q[WIDTH-2:0], serial_in};
      end else begin
        data_d = {serial_in, data_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign parallel_out = data_q;

`ifdef SIPO_WORD_VALID_EN
  localparam int unsigned CNT_W = sipo_cnt_width(WIDTH);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             word_valid_q;
  logic             word_valid_d;

  // Count shifted bits; the shift that completes a word wraps the count and raises the pulse.
  always_comb begin
    cnt_d        = cnt_q;
    word_valid_d = 1'b0;
    if (shift) begin
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        cnt_d        = '0;
        word_valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q        <= '0;
      word_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign word_valid = word_valid_q;
`endif

endmodule

// File: tb/tb_sipo_register.sv
// Self-checking bench for sipo_register: left- and right-shifting instances driven in lockstep.
module tb_sipo_register;

  logic       clock;
  logic       reset;
  logic       serial_in;
  logic       shift;
  logic [3:0] out_left;
  logic [3:0] out_right;
  logic       wv_left;
  logic       wv_right;

  int n_compared;
  int n_mismatched;

  typedef struct {
    logic       r;
    logic       s;
    logic       d;
    logic [3:0] el;
    logic [3:0] er;
    logic       wv;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] el;
    logic [3:0] er;
    logic       wv;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  sipo_register #(.WIDTH(4), .SHIFT_LEFT(1'b1)) u_left (
    .clock        (clock),
    .reset        (reset),
    .serial_in    (serial_in),
    .shift        (shift),
`ifdef SIPO_WORD_VALID_EN
    .word_valid   (wv_left),
`endif
    .parallel_out (out_left)
  );

  sipo_register #(.WIDTH(4), .SHIFT_LEFT(1'b0)) u_right (
    .clock        (clock),
    .reset        (reset),
    .serial_in    (serial_in),
    .shift        (shift),
`ifdef SIPO_WORD_VALID_EN
    .word_valid   (wv_right),
`endif
    .parallel_out (out_right)
  );

`ifndef SIPO_WORD_VALID_EN
  assign wv_left  = 1'b0;
  assign wv_right = 1'b0;
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, summary not printed");
    $fatal(1, "timeout");
  end

  task automatic check4(input string nm, input logic [3:0] act, input logic [3:0] exp_v);
    n_compared++;
    if (act !== exp_v) begin
      n_mismatched++;
      $display("FAIL %s: got %b expected %b", nm, act, exp_v);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp_v);
    n_compared++;
    if (act !== exp_v) begin
      n_mismatched++;
      $display("FAIL %s: got %b expected %b", nm, act, exp_v);
    end
  endtask

  // Pop the oldest expectation and compare it with both instances.
  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = sb.pop_front();
    check4({e.name, "/left"}, out_left, e.el);
    check4({e.name, "/right"}, out_right, e.er);
`ifdef SIPO_WORD_VALID_EN
    check1({e.name, "/wv_left"}, wv_left, e.wv);
    check1({e.name, "/wv_right"}, wv_right, e.wv);
`endif
  endtask

  task automatic apply(input string nm, input vec_t v);
    exp_t e;
    @(negedge clock);
    reset     = v.r;
    shift     = v.s;
    serial_in = v.d;
    e.name = nm;
    e.el   = v.el;
    e.er   = v.er;
    e.wv   = v.wv;
    sb.push_back(e);
    @(posedge clock);
    #1;
    compare_out();
  endtask

  function automatic vec_t mk(input logic r, input logic s, input logic d,
                              input logic [3:0] el, input logic [3:0] er, input logic wv);
    vec_t v;
    v.r = r; v.s = s; v.d = d; v.el = el; v.er = er; v.wv = wv;
    return v;
  endfunction

  initial begin
    exp_t e;
    n_compared   = 0;
    n_mismatched = 0;
    reset     = 1'b0;
    shift     = 1'b0;
    serial_in = 1'b0;

    // Reset beats shift
    vecs.push_back(mk(1, 1, 1, 4'b0000, 4'b0000, 0));
    vecs.push_back(mk(1, 1, 1, 4'b0000, 4'b0000, 0));
    // Fill with ones, fifth shift saturates
    vecs.push_back(mk(0, 1, 1, 4'b0001, 4'b1000, 0));
    vecs.push_back(mk(0, 1, 1, 4'b0011, 4'b1100, 0));
    vecs.push_back(mk(0, 1, 1, 4'b0111, 4'b1110, 0));
    vecs.push_back(mk(0, 1, 1, 4'b1111, 4'b1111, 1));
    vecs.push_back(mk(0, 1, 1, 4'b1111, 4'b1111, 0));
    // Order: 1,0,1,1
    vecs.push_back(mk(1, 0, 0, 4'b0000, 4'b0000, 0));
    vecs.push_back(mk(0, 1, 1, 4'b0001, 4'b1000, 0));
    vecs.push_back(mk(0, 1, 0, 4'b0010, 4'b0100, 0));
    vecs.push_back(mk(0, 1, 1, 4'b0101, 4'b1010, 0));
    vecs.push_back(mk(0, 1, 1, 4'b1011, 4'b1101, 1));
    // Load 1,0,1,0 then hold while serial_in toggles
    vecs.push_back(mk(1, 0, 0, 4'b0000, 4'b0000, 0));
    vecs.push_back(mk(0, 1, 1, 4'b0001, 4'b1000, 0));
    vecs.push_back(mk(0, 1, 0, 4'b0010, 4'b0100, 0));
    vecs.push_back(mk(0, 1, 1, 4'b0101, 4'b1010, 0));
    vecs.push_back(mk(0, 1, 0, 4'b1010, 4'b0101, 1));
    vecs.push_back(mk(0, 0, 1, 4'b1010, 4'b0101, 0));
    vecs.push_back(mk(0, 0, 0, 4'b1010, 4'b0101, 0));
    vecs.push_back(mk(0, 0, 1, 4'b1010, 4'b0101, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply($sformatf("vec%0d", i), vecs[i]);
    end

    // Shift pulsed only between edges must not move the register
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      shift     = 1'b1;
      serial_in = 1'b1;
      #2;
      shift     = 1'b0;
      serial_in = 1'b0;
      e.name = $sformatf("midcycle%0d", k);
      e.el = 4'b1010; e.er = 4'b0101; e.wv = 1'b0;
      sb.push_back(e);
      @(posedge clock);
      #1;
      compare_out();
    end

    // Mid-stream reset discards partial data
    apply("mr_rst0",  mk(1, 0, 0, 4'b0000, 4'b0000, 0));
    apply("mr_sh1",   mk(0, 1, 1, 4'b0001, 4'b1000, 0));
    apply("mr_sh2",   mk(0, 1, 1, 4'b0011, 4'b1100, 0));
    apply("mr_rst1",  mk(1, 1, 1, 4'b0000, 4'b0000, 0));
    apply("mr_sh3",   mk(0, 1, 1, 4'b0001, 4'b1000, 0));

    // Idle gaps between bits keep the count
    apply("gap_idle0", mk(0, 0, 1, 4'b0001, 4'b1000, 0));
    apply("gap_sh2",   mk(0, 1, 0, 4'b0010, 4'b0100, 0));
    apply("gap_idle1", mk(0, 0, 0, 4'b0010, 4'b0100, 0));
    apply("gap_sh3",   mk(0, 1, 1, 4'b0101, 4'b1010, 0));
    apply("gap_sh4",   mk(0, 1, 0, 4'b1010, 4'b0101, 1));

    // Reset after two shifts restarts the word count
    apply("wr_rst0", mk(1, 0, 0, 4'b0000, 4'b0000, 0));
    apply("wr_sh1",  mk(0, 1, 1, 4'b0001, 4'b1000, 0));
    apply("wr_sh2",  mk(0, 1, 1, 4'b0011, 4'b1100, 0));
    apply("wr_rst1", mk(1, 0, 0, 4'b0000, 4'b0000, 0));
    apply("wr_sh3",  mk(0, 1, 0, 4'b0000, 4'b0000, 0));
    apply("wr_sh4",  mk(0, 1, 0, 4'b0000, 4'b0000, 0));
    apply("wr_sh5",  mk(0, 1, 0, 4'b0000, 4'b0000, 0));
    apply("wr_sh6",  mk(0, 1, 1, 4'b0001, 4'b1000, 1));
    apply("wr_hold", mk(0, 0, 0, 4'b0001, 4'b1000, 0));

    n_compared++;
    if (sb.size() != 0) begin
      n_mismatched++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
